// File: rtl/clause_stream_loader.sv
// rtl/clause_stream_loader.sv - packs a signed-literal token stream into pos/neg clause masks,
// buffers the formula, then streams it to the solver as one contiguous load burst.
module clause_stream_loader #(
  parameter int NUM_LIT     = 30,
  parameter int VAR_W       = 5,
  parameter int MAX_CLAUSES = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [VAR_W-1:0]                   in_var,
  input  logic                               in_neg,
  input  logic                               in_last,
  input  logic                               in_eof,
  output logic                               load,
  output logic [NUM_LIT-1:0]                 i,
  output logic [$clog2(MAX_CLAUSES+1)-1:0]   clause_cnt,
  output logic                               done,
  output logic                               err
);
  localparam int DEPTH = 2 * MAX_CLAUSES;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(MAX_CLAUSES + 1);
  localparam logic [VAR_W-1:0]   NUM_LIT_V = VAR_W'(NUM_LIT);
  localparam logic [NUM_LIT-1:0] LIT_ONE   = NUM_LIT'(1);

  typedef enum logic [1:0] {COLLECT, STREAM, TERM, FINISH} state_t;

  state_t             state;
  logic               term_second;
  logic [NUM_LIT-1:0] pos_acc, neg_acc;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [NUM_LIT-1:0] mem [DEPTH];

  logic               accept, lit_ok, close_req, full, wr_en;
  logic [NUM_LIT-1:0] lit_mask, pos_next, neg_next, first_word;
  logic [PW-1:0]      wr_ptr_next;
  logic [AW-1:0]      wa0, wa1;

  assign in_ready = (state == COLLECT);

  always_comb begin
    accept     = in_valid && (state == COLLECT);
    lit_ok     = !in_eof && (in_var != '0) && (in_var <= NUM_LIT_V);
    // variable k lands on bit NUM_LIT-k, so variable 1 is the MSB
    lit_mask   = lit_ok ? (LIT_ONE << (NUM_LIT_V - in_var)) : '0;
    pos_next   = pos_acc | (in_neg ? '0 : lit_mask);
    neg_next   = neg_acc | (in_neg ? lit_mask : '0);
    close_req  = accept && (in_eof ? (|(pos_acc | neg_acc)) : (lit_ok && in_last));
    full       = (clause_cnt == CW'(MAX_CLAUSES));
    wr_en      = close_req && !full;
    wr_ptr_next = wr_en ? (wr_ptr + PW'(2)) : wr_ptr;
    wa0        = wr_ptr[AW-1:0];
    wa1        = wr_ptr[AW-1:0] + 1'b1;
    // the very first clause may be written on the same edge it must appear on i
    first_word = (wr_ptr == '0) ? pos_next : mem[0];
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wa0] <= pos_next;
      mem[wa1] <= neg_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      term_second <= 1'b0;
      pos_acc     <= '0;
      neg_acc     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      clause_cnt  <= '0;
      load        <= 1'b0;
      i           <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (!in_eof && !lit_ok)
              err <= 1'b1;
            if (close_req) begin
              pos_acc <= '0;
              neg_acc <= '0;
              if (full) begin
                err <= 1'b1;
              end else begin
                wr_ptr     <= wr_ptr_next;
                clause_cnt <= clause_cnt + CW'(1);
              end
            end else if (lit_ok) begin
              pos_acc <= pos_next;
              neg_acc <= neg_next;
            end
            if (in_eof) begin
              load        <= 1'b1;
              term_second <= 1'b0;
              if (wr_ptr_next == '0) begin
                state <= TERM;
                i     <= '0;
              end else begin
                state  <= STREAM;
                i      <= first_word;
                rd_ptr <= PW'(1);
              end
            end
          end
        end
        STREAM: begin
          if (rd_ptr == wr_ptr) begin
            state <= TERM;
            i     <= '0;
          end else begin
            i      <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PW'(1);
          end
        end
        TERM: begin
          if (term_second) begin
            state <= FINISH;
            load  <= 1'b0;
            done  <= 1'b1;
          end else begin
            term_second <= 1'b1;
          end
        end
        default: begin
          load <= 1'b0;
          i    <= '0;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clause_stream_loader.sv
// tb/tb_clause_stream_loader.sv - randomized and directed bench for clause_stream_loader
// against a token-level reference model.
module tb_clause_stream_loader;
  localparam int NUM_LIT     = 30;
  localparam int VAR_W       = 5;
  localparam int MAX_CLAUSES = 32;
  localparam int CW          = $clog2(MAX_CLAUSES + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid, in_ready;
  logic [VAR_W-1:0]   in_var;
  logic               in_neg, in_last, in_eof;
  logic               load;
  logic [NUM_LIT-1:0] i;
  logic [CW-1:0]      clause_cnt;
  logic               done, err;

  clause_stream_loader #(.NUM_LIT(NUM_LIT), .VAR_W(VAR_W), .MAX_CLAUSES(MAX_CLAUSES)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_var(in_var), .in_neg(in_neg), .in_last(in_last), .in_eof(in_eof),
    .load(load), .i(i), .clause_cnt(clause_cnt), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int v;
    bit neg;
    bit last;
    bit eof;
  } tok_t;

  tok_t               toks[$];
  logic [NUM_LIT-1:0] exp_words[$];
  logic [NUM_LIT-1:0] got[$];
  bit                 exp_err;
  int                 exp_cnt;

  function automatic void add(input int v, input bit neg, input bit last);
    toks.push_back('{v: v, neg: neg, last: last, eof: 1'b0});
  endfunction

  function automatic void add_eof();
    toks.push_back('{v: 0, neg: 1'b0, last: 1'b0, eof: 1'b1});
  endfunction

  // Reference: walk the token list, build each clause as two masks, honour capacity.
  task automatic model();
    logic [NUM_LIT-1:0] p, n;
    bit do_close;
    p = '0; n = '0;
    exp_words.delete();
    exp_err = 0;
    exp_cnt = 0;
    foreach (toks[t]) begin
      do_close = 0;
      if (toks[t].eof) begin
        do_close = ((p | n) != '0);
      end else if (toks[t].v < 1 || toks[t].v > NUM_LIT) begin
        exp_err = 1;
      end else begin
        if (toks[t].neg) n[NUM_LIT - toks[t].v] = 1'b1;
        else             p[NUM_LIT - toks[t].v] = 1'b1;
        do_close = toks[t].last;
      end
      if (do_close) begin
        if (exp_cnt == MAX_CLAUSES) begin
          exp_err = 1;
        end else begin
          exp_words.push_back(p);
          exp_words.push_back(n);
          exp_cnt++;
        end
        p = '0; n = '0;
      end
      if (toks[t].eof) break;
    end
    exp_words.push_back('0);
    exp_words.push_back('0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    toks.delete();
  endtask

  task automatic send_tokens(input bit gaps, input bit hold);
    foreach (toks[t]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clock);
          in_valid = 1'b0;
        end
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_var   = VAR_W'(toks[t].v);
      in_neg   = toks[t].neg;
      in_last  = toks[t].last;
      in_eof   = toks[t].eof;
      @(posedge clock);
    end
    @(negedge clock);
    in_valid = hold;
    in_eof   = 1'b0;
    in_last  = 1'b1;
    in_var   = VAR_W'(3);
  endtask

  task automatic collect(input string name, input bit hold);
    int cyc;
    got.delete();
    cyc = 0;
    check({name, "_first_latency"}, 64'(load), 64'd1);
    while (load && cyc < 200) begin
      got.push_back(i);
      if (hold) check({name, "_ready_low_stream"}, 64'(in_ready), 64'd0);
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    check({name, "_load_cycles"}, 64'(got.size()), 64'(exp_words.size()));
    foreach (exp_words[k])
      if (k < got.size()) check($sformatf("%s_word%0d", name, k), 64'(got[k]), 64'(exp_words[k]));
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_clause_cnt"}, 64'(clause_cnt), 64'(exp_cnt));
    check({name, "_ready_finish"}, 64'(in_ready), 64'd0);
    @(negedge clock);
    check({name, "_load_held_low"}, 64'(load), 64'd0);
  endtask

  task automatic run(input string name, input bit gaps, input bit hold);
    model();
    check({name, "_ready_start"}, 64'(in_ready), 64'd1);
    send_tokens(gaps, hold);
    collect(name, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, nl;
    bit pending;
    reset = 1'b1; in_valid = 1'b0; in_var = '0; in_neg = 1'b0; in_last = 1'b0; in_eof = 1'b0;
    #12;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_load", 64'(load), 64'd0);
    check("rst_i", 64'(i), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cnt", 64'(clause_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // single clause (x1 | ~x4)
    toks.delete();
    add(1, 0, 0); add(4, 1, 1); add_eof();
    run("single", 0, 0);
    check("single_pos_const", 64'(got.size() > 0 ? got[0] : 'x), 64'h2000_0000);
    check("single_neg_const", 64'(got.size() > 1 ? got[1] : 'x), 64'h0400_0000);

    do_reset();
    add(2, 0, 0); add(3, 0, 1); add(29, 1, 0); add(30, 1, 1); add_eof();
    run("two", 0, 0);
    check("two_neg2_const", 64'(got.size() > 3 ? got[3] : 'x), 64'h3);

    do_reset();
    add(0, 0, 0); add(31, 1, 0); add(5, 0, 1); add_eof();
    run("badvar", 0, 0);
    check("badvar_pos_const", 64'(got.size() > 0 ? got[0] : 'x), 64'h0200_0000);

    do_reset();
    add(1, 0, 0); add_eof();
    run("pending", 0, 0);

    do_reset();
    add_eof();
    run("empty", 0, 0);

    do_reset();
    for (int c = 0; c <= MAX_CLAUSES; c++) begin
      add(c % NUM_LIT + 1, c[0], 0);
      add((c * 7) % NUM_LIT + 1, ~c[0], 1);
    end
    add_eof();
    run("overflow", 0, 1);

    // asynchronous reset in the middle of a stream
    do_reset();
    add(6, 0, 1); add(7, 1, 1); add(8, 0, 1); add_eof();
    model();
    send_tokens(0, 0);
    @(negedge clock);
    check("async_pre_load", 64'(load), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_load", 64'(load), 64'd0);
    check("async_i", 64'(i), 64'd0);
    check("async_done", 64'(done), 64'd0);
    check("async_ready", 64'(in_ready), 64'd1);
    check("async_cnt", 64'(clause_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    toks.delete();
    add(9, 1, 0); add(10, 0, 1); add_eof();
    run("after_async", 0, 0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      nc = $urandom_range(0, MAX_CLAUSES + 3);
      pending = $urandom_range(0, 1);
      for (int c = 0; c < nc; c++) begin
        nl = $urandom_range(1, 4);
        for (int l = 0; l < nl; l++) begin
          if ($urandom_range(0, 9) == 0) add(($urandom_range(0, 1) != 0) ? 31 : 0, 1'($urandom_range(0, 1)), 0);
          add($urandom_range(1, NUM_LIT), 1'($urandom_range(0, 1)),
              (l == nl - 1) && !(pending && c == nc - 1));
        end
      end
      add_eof();
      run($sformatf("rand%0d", r), 1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
